uart_transmitter: RTL

Serialises one DATA_WIDTH-bit word per request into an asynchronous UART frame: start bit, data LSB first, optional parity bit, stop bit. It is the transmit-side counterpart of the UART receiver and uses the same configuration inputs (parity_enable, parity_type, prescale) so both ends can be wired back to back. Each bit is held on the line for prescale cycles of clk.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_transmitter_bit_timer.sv | 36 +++
 rtl/uart_transmitter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, parity
// and line-level constants, and the parity helper.
package uart_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   localparam logic LINE_IDLE = 1'b1;

   // Parity bit from the XOR-reduction of the word and the selected type.
   function automatic logic parity_bit(input logic red_xor, input logic ptype);
      logic res;
      case (ptype)
         PARITY_EVEN: res = red_xor;
         PARITY_ODD:  res = ~red_xor;
         default:     res = red_xor;
      endcase
      return res;
   endfunction

endpackage : uart_pkg

// File: rtl/uart_transmitter_bit_timer.sv
// Bit-time counter: counts 0..prescale-1 and flags the last cycle of each bit.
module uart_bit_timer #(
   parameter int unsigned PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear_i,
   input  logic [PRESCALE_WIDTH-1:0] prescale_i,
   output logic                      bit_tick_c,
   output logic                      tick_next_c
);

   localparam int unsigned PW = PRESCALE_WIDTH;

   logic [PW-1:0] cnt_q;
   logic [PW-1:0] cnt_d;

   // prescale_i is already clamped to >= 1 by the caller
   always_comb begin
      bit_tick_c = (cnt_q == (prescale_i - PW'(1)));
      cnt_d      = cnt_q + PW'(1);
      if (clear_i || bit_tick_c) begin
         cnt_d = '0;
      end
      tick_next_c = (cnt_d == (prescale_i - PW'(1)));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : uart_bit_timer

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity,
// stop bit. Define UART_TX_HOLD_REG_EN for a one-entry holding register.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      parity_enable,
   input  logic                      parity_type,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic [DATA_WIDTH-1:0]     parallel_data,
   input  logic                      data_valid,
   output logic                      ready,
   output logic                      serial_data_out,
   output logic                      busy,
   output logic                      frame_done
);

   localparam int unsigned PW        = PRESCALE_WIDTH;
   localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   logic [STATE_W-1:0]    state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic                  par_en_q, par_en_d;
   logic                  par_bit_q, par_bit_d;
   logic [PW-1:0]         presc_q, presc_d;

   logic serial_q, serial_d;
   logic busy_q, busy_d;
   logic ready_q, ready_d;
   logic done_q, done_d;

   logic bit_tick_c, tick_next_c, timer_clear_c;
   logic accept_c, start_c;

   logic [DATA_WIDTH-1:0] load_data_c;
   logic                  load_pe_c;
   logic                  load_pt_c;
   logic [PW-1:0]         load_presc_c;

   assign accept_c = data_valid & ready_q;

`ifdef UART_TX_HOLD_REG_EN
   logic                  hold_full_q, hold_full_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  hold_pe_q, hold_pe_d;
   logic                  hold_pt_q, hold_pt_d;
   logic [PW-1:0]         hold_presc_q, hold_presc_d;
   logic                  frame_end_c;

   // A held word has priority; otherwise a word accepted at the start point bypasses the holding register.
   assign frame_end_c  = (state_q == ST_STOP) & bit_tick_c;
   assign start_c      = ((state_q == ST_IDLE) | frame_end_c) & (hold_full_q | accept_c);
   assign load_data_c  = hold_full_q ? hold_data_q  : parallel_data;
   assign load_pe_c    = hold_full_q ? hold_pe_q    : parity_enable;
   assign load_pt_c    = hold_full_q ? hold_pt_q    : parity_type;
   assign load_presc_c = hold_full_q ? hold_presc_q : prescale;

   always_comb begin
      hold_full_d  = hold_full_q;
      hold_data_d  = hold_data_q;
      hold_pe_d    = hold_pe_q;
      hold_pt_d    = hold_pt_q;
      hold_presc_d = hold_presc_q;
      if (start_c && hold_full_q) begin
         hold_full_d = 1'b0;
      end
      if (accept_c && !(start_c && !hold_full_q)) begin
         hold_full_d  = 1'b1;
         hold_data_d  = parallel_data;
         hold_pe_d    = parity_enable;
         hold_pt_d    = parity_type;
         hold_presc_d = prescale;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_full_q  <= 1'b0;
         hold_data_q  <= '0;
         hold_pe_q    <= 1'b0;
         hold_pt_q    <= 1'b0;
         hold_presc_q <= '0;
      end else begin
         hold_full_q  <= hold_full_d;
         hold_data_q  <= hold_data_d;
         hold_pe_q    <= hold_pe_d;
         hold_pt_q    <= hold_pt_d;
         hold_presc_q <= hold_presc_d;
      end
   end

   // Ready also rises in the final stop cycle, when the held word frees its slot.
   assign ready_d = ~hold_full_d | ((state_d == ST_STOP) & tick_next_c);
`else
   assign start_c      = (state_q == ST_IDLE) & accept_c;
   assign load_data_c  = parallel_data;
   assign load_pe_c    = parity_enable;
   assign load_pt_c    = parity_type;
   assign load_presc_c = prescale;
   assign ready_d      = (state_d == ST_IDLE);
`endif

   uart_bit_timer #(
      .PRESCALE_WIDTH(PW)
   ) u_bit_timer (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (timer_clear_c),
      .prescale_i (presc_q),
      .bit_tick_c (bit_tick_c),
      .tick_next_c(tick_next_c)
   );

   // Next-state, datapath and registered-output lookahead.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      presc_d   = presc_q;

      case (state_q)
         ST_IDLE: begin
            if (start_c) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick_c) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (bit_tick_c) begin
               if (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? ST_PARITY : ST_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                  shift_d   = shift_q >> 1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_tick_c) begin
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_tick_c) begin
               state_d = start_c ? ST_START : ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Latch the word and its configuration whenever a frame starts.
      if (start_c) begin
         shift_d   = load_data_c;
         bit_cnt_d = '0;
         par_en_d  = load_pe_c;
         par_bit_d = parity_bit(^load_data_c, load_pt_c);
         presc_d   = (load_presc_c == '0) ? PW'(1) : load_presc_c;
      end

      timer_clear_c = (state_d != state_q) | (state_q == ST_IDLE);
      busy_d        = (state_d != ST_IDLE);
      done_d        = (state_d == ST_STOP) & tick_next_c;

      case (state_d)
         ST_START:  serial_d = 1'b0;
         ST_DATA:   serial_d = shift_d[0];
         ST_PARITY: serial_d = par_bit_d;
         default:   serial_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         presc_q   <= PW'(1);
         serial_q  <= LINE_IDLE;
         busy_q    <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         presc_q   <= presc_d;
         serial_q  <= serial_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
      end
   end

   assign serial_data_out = serial_q;
   assign busy            = busy_q;
   assign ready           = ready_q;
   assign frame_done      = done_q;

endmodule : uart_transmitter
